// File: rtl/btn_debounce.sv
// Per-channel push-button conditioner: 2-flop synchroniser, debounce counter,
// registered press/release pulses and a once-per-press long-hold pulse.
module btn_debounce #(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned HOLD_CYCLES     = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold
);

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DbW-1:0]   DbMax    = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldFire = HoldW'(HOLD_CYCLES - 2);
    localparam logic [HoldW-1:0] HoldSat  = HoldW'(HOLD_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] stable_q, stable_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] hold_q, hold_d;
    logic [DbW-1:0]     db_cnt_q   [NUM_BTN];
    logic [DbW-1:0]     db_cnt_d   [NUM_BTN];
    logic [HoldW-1:0]   hold_cnt_q [NUM_BTN];
    logic [HoldW-1:0]   hold_cnt_d [NUM_BTN];

    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        hold_d    = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i]   = '0;
            hold_cnt_d[i] = '0;

            // Any cycle matching the accepted level drops the count, so bounces restart it.
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    stable_d[i]  = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end

            // Saturating at HOLD_CYCLES-1 guarantees a single hold pulse per press.
            if (stable_q[i]) begin
                if (hold_cnt_q[i] != HoldSat) begin
                    hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i];
                end
                hold_d[i] = (hold_cnt_q[i] == HoldFire);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            hold_q    <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_hold    = hold_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random button activity, checked
// every cycle against a run-length based reference model.
module tb_btn_debounce;

    localparam int unsigned NB = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned HC = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold;

    always #5 clk = ~clk;

    btn_debounce #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NB-1:0] m_stable, e_press, e_release, e_hold, m_prev;
    logic [NB-1:0] samp_q[$];
    int            m_run[NB];
    int            m_press_at[NB];
    int            cyc = 0;

    // Observed pulse tallies for scenario-level checks
    int n_press[NB];
    int n_rel[NB];
    int n_hold[NB];
    int n_sim;

    function automatic void model_clear();
        m_stable  = '0;
        e_press   = '0;
        e_release = '0;
        e_hold    = '0;
        m_prev    = '0;
        samp_q.delete();
        for (int c = 0; c < NB; c++) begin
            m_run[c]      = 0;
            m_press_at[c] = 0;
        end
    endfunction

    // A level is accepted once the synchronised input has held one value, different
    // from the accepted level, for DB consecutive cycles.
    function automatic void model_edge(input logic [NB-1:0] raw);
        logic [NB-1:0] sync;
        cyc++;
        e_press   = '0;
        e_release = '0;
        e_hold    = '0;
        sync = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : '0;
        samp_q.push_back(raw);
        if (samp_q.size() > 2) void'(samp_q.pop_front());
        for (int c = 0; c < NB; c++) begin
            if (sync[c] == m_prev[c]) m_run[c]++;
            else begin
                m_run[c]  = 1;
                m_prev[c] = sync[c];
            end
            if (m_stable[c] && (cyc - m_press_at[c] == int'(HC) - 1)) e_hold[c] = 1'b1;
            if (sync[c] != m_stable[c] && m_run[c] >= int'(DB)) begin
                m_stable[c] = sync[c];
                if (sync[c]) begin
                    e_press[c]    = 1'b1;
                    m_press_at[c] = cyc;
                end else begin
                    e_release[c] = 1'b1;
                end
            end
        end
    endfunction

    task automatic check();
        checks++;
        assert (btn_level === m_stable) else begin
            errors++;
            $error("FAIL level: got %b expected %b (cycle %0d)", btn_level, m_stable, cyc);
        end
        checks++;
        assert (btn_press === e_press) else begin
            errors++;
            $error("FAIL press: got %b expected %b (cycle %0d)", btn_press, e_press, cyc);
        end
        checks++;
        assert (btn_release === e_release) else begin
            errors++;
            $error("FAIL release: got %b expected %b (cycle %0d)", btn_release, e_release, cyc);
        end
        checks++;
        assert (btn_hold === e_hold) else begin
            errors++;
            $error("FAIL hold: got %b expected %b (cycle %0d)", btn_hold, e_hold, cyc);
        end
        for (int c = 0; c < NB; c++) begin
            n_press[c] += int'(btn_press[c]);
            n_rel[c]   += int'(btn_release[c]);
            n_hold[c]  += int'(btn_hold[c]);
        end
        if (btn_press == 3'b101) n_sim++;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst) model_edge(btn_raw);
            #1;
            check();
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NB; c++) begin
            n_press[c] = 0;
            n_rel[c]   = 0;
            n_hold[c]  = 0;
        end
        n_sim = 0;
    endtask

    task automatic chk_count(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        model_clear();
        check();
        step(n);
        rst = 1'b1;
    endtask

    int bpat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        rst     = 1'b1;
        btn_raw = '1;
        #2;
        clear_counts();

        // Reset held with all buttons pressed, then released
        do_reset(20);
        step(8);
        for (int c = 0; c < NB; c++) chk_count("reset_release_press", n_press[c], 1);

        btn_raw = '0;
        step(10);

        // Clean press and release on channel 0
        clear_counts();
        btn_raw = 3'b001;
        step(10);
        btn_raw = 3'b000;
        step(10);
        chk_count("clean_press0", n_press[0], 1);
        chk_count("clean_release0", n_rel[0], 1);

        // Bouncing press on channel 1
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            btn_raw = {1'b0, bpat[i][0], 1'b0};
            step(1);
        end
        step(8);
        chk_count("bounce_press1", n_press[1], 1);
        btn_raw = '0;
        step(12);

        // Three-cycle glitch is ignored
        clear_counts();
        btn_raw = 3'b010;
        step(3);
        btn_raw = 3'b000;
        step(10);
        chk_count("glitch_press1", n_press[1], 0);
        chk_count("glitch_release1", n_rel[1], 0);

        // Long hold on channel 2, then a second press
        clear_counts();
        btn_raw = 3'b100;
        step(30);
        chk_count("hold_press2", n_press[2], 1);
        chk_count("hold_once2", n_hold[2], 1);
        btn_raw = 3'b000;
        step(10);
        btn_raw = 3'b100;
        step(15);
        chk_count("hold_again2", n_hold[2], 2);
        btn_raw = 3'b000;
        step(10);

        // Reset in the middle of qualifying a press
        clear_counts();
        btn_raw = 3'b001;
        step(4);
        do_reset(2);
        step(10);
        chk_count("midreset_press0", n_press[0], 1);
        btn_raw = 3'b000;
        step(10);

        // Simultaneous press on channels 0 and 2
        clear_counts();
        btn_raw = 3'b101;
        step(8);
        chk_count("sim_vector", n_sim, 1);
        chk_count("sim_press1", n_press[1], 0);
        btn_raw = 3'b000;
        step(10);

        // Random activity with occasional resets
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(11, 0) == 0) btn_raw[c] = ~btn_raw[c];
            end
            if ($urandom_range(399, 0) == 0) do_reset(2);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
